// File: rtl/rx_interface_pkg.sv
// rx_interface_pkg: shared FSM state encodings and width defaults for the UART/ALU front end.
package rx_interface_pkg;
    localparam int DEF_WIDTH_WORD   = 8;
    localparam int DEF_WIDTH_OPCODE = 6;
    // One-hot so that any corrupted encoding is trivially distinct from every legal state.
    typedef enum logic [4:0] {
        ESPERA_A      = 5'b00001,
        ESPERA_B      = 5'b00010,
        ESPERA_OPCODE = 5'b00100,
        EJECUTAR      = 5'b01000,
        ESPERA_TX     = 5'b10000
    } state_t;
endpackage

// File: rtl/rx_interface_if.sv
// rx_interface_if: bus between UART rx/tx, ALU and the frame collector.
//   rx_done/data_in   : received-byte level and data
//   alu_result        : combinational ALU output for the current operands
//   tx_done           : transmitter-finished level
//   operando_a/b      : registered ALU operands
//   opcode            : registered ALU opcode
//   data_out/tx_start : registered transmit byte and one-clock request
interface rx_interface_if import rx_interface_pkg::*; #(
    parameter int WIDTH_WORD   = DEF_WIDTH_WORD,
    parameter int WIDTH_OPCODE = DEF_WIDTH_OPCODE
) ();
    logic                    rx_done;
    logic [WIDTH_WORD-1:0]   data_in;
    logic [WIDTH_WORD-1:0]   alu_result;
    logic                    tx_done;
    logic [WIDTH_WORD-1:0]   operando_a;
    logic [WIDTH_WORD-1:0]   operando_b;
    logic [WIDTH_OPCODE-1:0] opcode;
    logic [WIDTH_WORD-1:0]   data_out;
    logic                    tx_start;
    modport slave (
        input  rx_done, data_in, alu_result, tx_done,
        output operando_a, operando_b, opcode, data_out, tx_start
    );
    modport master (
        output rx_done, data_in, alu_result, tx_done,
        input  operando_a, operando_b, opcode, data_out, tx_start
    );
endinterface

// File: rtl/rx_interface_detector_flanco.sv
// detector_flanco: 1-bit rising-edge detector.
//   i_clock/i_reset : clock, synchronous active-high reset
//   i_signal        : level input
//   o_flanco        : high while i_signal is high and its previous sample was low
module detector_flanco (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_signal,
    output logic o_flanco
);
    logic prev;
    // Reset captures the live level so a signal already high at release is not an edge.
    always_ff @(posedge i_clock) prev <= i_signal;
    assign o_flanco = i_signal & ~prev & ~i_reset;
endmodule

// File: rtl/rx_interface.sv
// rx_interface: collects operand A, operand B and opcode bytes from the UART, then sends the ALU result.
//   i_clock/i_reset : clock, synchronous active-high reset
//   bus (slave)     : rx/tx handshakes, ALU operands/opcode/result, transmit byte and request
module rx_interface import rx_interface_pkg::*; #(
    parameter int WIDTH_WORD   = DEF_WIDTH_WORD,
    parameter int WIDTH_OPCODE = DEF_WIDTH_OPCODE
) (
    input logic           i_clock,
    input logic           i_reset,
    rx_interface_if.slave bus
);
    state_t                  state;
    logic                    rx_flanco, tx_flanco;
    logic [WIDTH_WORD-1:0]   operando_a, operando_b, data_out;
    logic [WIDTH_OPCODE-1:0] opcode;
    logic                    tx_start;

    detector_flanco u_rx (.i_clock(i_clock), .i_reset(i_reset), .i_signal(bus.rx_done), .o_flanco(rx_flanco));
    detector_flanco u_tx (.i_clock(i_clock), .i_reset(i_reset), .i_signal(bus.tx_done), .o_flanco(tx_flanco));

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state      <= ESPERA_A;
            operando_a <= '0;
            operando_b <= '0;
            opcode     <= '0;
            data_out   <= '0;
            tx_start   <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                ESPERA_A: if (rx_flanco) begin
                    operando_a <= bus.data_in;
                    state      <= ESPERA_B;
                end
                ESPERA_B: if (rx_flanco) begin
                    operando_b <= bus.data_in;
                    state      <= ESPERA_OPCODE;
                end
                ESPERA_OPCODE: if (rx_flanco) begin
                    opcode <= bus.data_in[WIDTH_OPCODE-1:0];
                    state  <= EJECUTAR;
                end
                EJECUTAR: begin
                    data_out <= bus.alu_result;
                    tx_start <= 1'b1;
                    state    <= ESPERA_TX;
                end
                // rx edges here are dropped; only a fresh tx edge closes the frame.
                ESPERA_TX: if (tx_flanco) state <= ESPERA_A;
                default: state <= ESPERA_A;
            endcase
        end
    end

    assign bus.operando_a = operando_a;
    assign bus.operando_b = operando_b;
    assign bus.opcode     = opcode;
    assign bus.data_out   = data_out;
    assign bus.tx_start   = tx_start;
endmodule

// File: tb/tb_rx_interface.sv
// tb_rx_interface: scoreboard bench for rx_interface with an A+B ALU model.
module tb_rx_interface;
    import rx_interface_pkg::*;
    logic i_clock, i_reset;
    int n_tests = 0, n_fail = 0;
    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] op;
        logic [7:0] d;
    } exp_t;
    exp_t sb[$];
    logic prev_tx_start = 1'b0;

    rx_interface_if #(.WIDTH_WORD(8), .WIDTH_OPCODE(6)) bus ();
    rx_interface #(.WIDTH_WORD(8), .WIDTH_OPCODE(6)) dut (.i_clock(i_clock), .i_reset(i_reset), .bus(bus));

    assign bus.alu_result = bus.operando_a + bus.operando_b;

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    always @(posedge i_clock) begin
        #1;
        if (bus.tx_start) begin
            chk("tx_pulse_len", 32'(prev_tx_start), 0);
            if (sb.size() == 0) chk("sb_underflow", 1, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_a", 32'(bus.operando_a), 32'(e.a));
                chk("sb_b", 32'(bus.operando_b), 32'(e.b));
                chk("sb_op", 32'(bus.opcode), 32'(e.op));
                chk("sb_data", 32'(bus.data_out), 32'(e.d));
            end
        end
        prev_tx_start = bus.tx_start;
    end

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        exp_t e;
        e.a = a;
        e.b = b;
        e.op = c[5:0];
        e.d = a + b;
        sb.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] v, input int hold);
        @(posedge i_clock); #1;
        bus.rx_done = 1'b1;
        bus.data_in = v;
        repeat (hold) @(posedge i_clock);
        #1 bus.rx_done = 1'b0;
    endtask

    task automatic tx_pulse();
        @(posedge i_clock); #1 bus.tx_done = 1'b1;
        @(posedge i_clock); #1 bus.tx_done = 1'b0;
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input int hold);
        push(a, b, c);
        send_byte(a, hold);
        send_byte(b, hold);
        send_byte(c, hold);
        repeat (2) @(posedge i_clock);
        #2 chk("sb_drain", sb.size(), 0);
    endtask

    initial begin
        bus.rx_done = 1'b1;
        bus.data_in = 8'h55;
        bus.tx_done = 1'b0;
        i_reset = 1'b1;
        repeat (3) @(posedge i_clock);
        #1 i_reset = 1'b0;
        chk("rst_a", 32'(bus.operando_a), 0);
        chk("rst_b", 32'(bus.operando_b), 0);
        chk("rst_op", 32'(bus.opcode), 0);
        chk("rst_data", 32'(bus.data_out), 0);
        chk("rst_tx_start", 32'(bus.tx_start), 0);
        repeat (2) @(posedge i_clock);
        #1 chk("held_rx_no_edge_state", 32'(dut.state), 32'(ESPERA_A));
        chk("held_rx_no_edge_a", 32'(bus.operando_a), 0);
        bus.rx_done = 1'b0;

        // Basic frame with exact tx_start timing.
        push(8'h05, 8'h03, 8'h20);
        send_byte(8'h05, 1);
        send_byte(8'h03, 1);
        @(posedge i_clock); #1;
        bus.rx_done = 1'b1;
        bus.data_in = 8'h20;
        @(posedge i_clock); #1 bus.rx_done = 1'b0;
        chk("t1_op", 32'(bus.opcode), 32'h20);
        chk("t1_tx_start_early", 32'(bus.tx_start), 0);
        @(posedge i_clock); #1;
        chk("t1_tx_start", 32'(bus.tx_start), 1);
        @(posedge i_clock); #1;
        chk("t1_tx_start_after", 32'(bus.tx_start), 0);
        chk("t1_data", 32'(bus.data_out), 32'h08);
        chk("t1_drain", sb.size(), 0);
        tx_pulse();
        chk("t1_back_to_a", 32'(dut.state), 32'(ESPERA_A));

        // Long rx_done levels count once per byte.
        frame(8'hFF, 8'h01, 8'h3F, 40);
        chk("t2_a", 32'(bus.operando_a), 32'hFF);
        chk("t2_b", 32'(bus.operando_b), 32'h01);
        chk("t2_op", 32'(bus.opcode), 32'h3F);
        chk("t2_state", 32'(dut.state), 32'(ESPERA_TX));

        // Byte during ESPERA_TX is dropped.
        send_byte(8'hAA, 1);
        repeat (2) @(posedge i_clock);
        #1 chk("t3_drop_a", 32'(bus.operando_a), 32'hFF);
        tx_pulse();
        push(8'h11, 8'h22, 8'h01);
        send_byte(8'h11, 1);
        @(posedge i_clock); #1;
        chk("t3_a", 32'(bus.operando_a), 32'h11);
        chk("t3_state", 32'(dut.state), 32'(ESPERA_B));
        send_byte(8'h22, 1);
        send_byte(8'h01, 1);
        repeat (2) @(posedge i_clock);
        #2 chk("t3_drain", sb.size(), 0);
        tx_pulse();

        // Reset mid-frame.
        send_byte(8'h7E, 1);
        @(posedge i_clock); #1;
        chk("t4_a_pre", 32'(bus.operando_a), 32'h7E);
        i_reset = 1'b1;
        @(posedge i_clock); #1 i_reset = 1'b0;
        chk("t4_a", 32'(bus.operando_a), 0);
        chk("t4_b", 32'(bus.operando_b), 0);
        chk("t4_op", 32'(bus.opcode), 0);
        chk("t4_data", 32'(bus.data_out), 0);
        chk("t4_state", 32'(dut.state), 32'(ESPERA_A));
        frame(8'h02, 8'h03, 8'h01, 1);
        chk("t4_next_a", 32'(bus.operando_a), 32'h02);
        tx_pulse();

        // Upper opcode bits discarded.
        frame(8'h10, 8'h20, 8'hE5, 1);
        chk("t5_op", 32'(bus.opcode), 32'h25);
        tx_pulse();

        // tx_done held high across a frame does not end ESPERA_TX.
        @(posedge i_clock); #1 bus.tx_done = 1'b1;
        frame(8'h40, 8'h02, 8'h07, 1);
        send_byte(8'h99, 1);
        repeat (5) @(posedge i_clock);
        #1 chk("t6_stuck_state", 32'(dut.state), 32'(ESPERA_TX));
        chk("t6_a_hold", 32'(bus.operando_a), 32'h40);
        bus.tx_done = 1'b0;
        tx_pulse();
        chk("t6_released", 32'(dut.state), 32'(ESPERA_A));

        repeat (3) @(posedge i_clock);
        #1 chk("final_sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
